// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam int NREG  = 16;
  localparam int RW    = 4;
  localparam int LAT_W = 3;

  typedef logic [RW-1:0]    regid_t;
  typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/hazard_controller_sb_entry.sv
// sb_entry: one scoreboard slot. A down-counter that loads a latency,
// counts down while enabled and reports busy while nonzero.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         busy
);

  logic [W-1:0] cnt;

  // Load wins over decrement; decrement stops at zero and holds while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: per-register scoreboard of in-flight long-latency
// results plus a busy tracker for the single non-pipelined vector unit.
// Stalls IF/ID and bubbles EX while a source, destination (WAW) or the
// vector unit is still pending. Single-cycle results are left to forwarding.
// Optional build macro HAZARD_STATS_EN adds stats_clr / stall_count
// (saturating count of EX bubbles).
module hazard_controller #(
  parameter int NREG  = hazard_pkg::NREG,
  parameter int RW    = hazard_pkg::RW,
  parameter int LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs2,
  input  logic [RW-1:0]    id_rs3,
  input  logic             id_rs2_use,
  input  logic             id_rs3_use,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_wr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             id_vec,
  input  logic             mem_busy,
  input  logic             flush,
`ifdef HAZARD_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      stall_count,
`endif
  output logic             issue,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [NREG-1:0]  busy_vec
);

  import hazard_pkg::*;

  logic live;
  logic hazard;
  logic vec_busy;

  // Register 0 is hardwired zero and never pending.
  assign busy_vec[0] = 1'b0;

  // Hazard detection and pipeline control; held quiet while in reset.
  always_comb begin
    hazard = 1'b0;
    if (id_rs2_use && (id_rs2 != '0) && busy_vec[id_rs2]) hazard = 1'b1;
    if (id_rs3_use && (id_rs3 != '0) && busy_vec[id_rs3]) hazard = 1'b1;
    if (id_wr && (id_rd != '0) && busy_vec[id_rd])        hazard = 1'b1;
    if (id_vec && vec_busy)                              hazard = 1'b1;
    live      = ~rst & id_valid & ~flush;
    issue     = live & ~hazard & ~mem_busy;
    stall_if  = live & (hazard | mem_busy);
    stall_id  = live & (hazard | mem_busy);
    bubble_ex = live & hazard & ~mem_busy;
  end

  // One slot per architectural register 1..NREG-1; lat=0 results are
  // forwardable immediately and are not tracked.
  for (genvar i = 1; i < NREG; i++) begin : g_reg
    sb_entry #(.W(LAT_W)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .load     (issue & id_wr & (id_rd == RW'(i)) & (id_lat != '0)),
      .load_val (id_lat),
      .dec_en   (~mem_busy),
      .busy     (busy_vec[i])
    );
  end

  sb_entry #(.W(LAT_W)) u_vec (
    .clk      (clk),
    .rst      (rst),
    .load     (issue & id_vec),
    .load_val (id_lat),
    .dec_en   (~mem_busy),
    .busy     (vec_busy)
  );

`ifdef HAZARD_STATS_EN
  // Saturating bubble counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stall_count <= '0;
    end else if (bubble_ex && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: cycle table through a
// scoreboard queue, a latency sweep, and (with HAZARD_STATS_EN) the
// bubble counter.
module tb_hazard_controller;

  typedef struct {
    logic        rst, valid;
    logic [3:0]  rs2;
    logic        u2;
    logic [3:0]  rs3;
    logic        u3;
    logic [3:0]  rd;
    logic        wr;
    logic [2:0]  lat;
    logic        vec, mb, fl;
    logic        e_iss, e_stl, e_bub;
    logic [15:0] e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_rs2_use, id_rs3_use, id_wr, id_vec, mem_busy, flush;
  logic [3:0]  id_rs2, id_rs3, id_rd;
  logic [2:0]  id_lat;
  logic        issue, stall_if, stall_id, bubble_ex;
  logic [15:0] busy_vec;
  logic        stats_clr;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  int tests = 0;
  int failed = 0;
  vec_t tbl[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs2     (id_rs2),
    .id_rs3     (id_rs3),
    .id_rs2_use (id_rs2_use),
    .id_rs3_use (id_rs3_use),
    .id_rd      (id_rd),
    .id_wr      (id_wr),
    .id_lat     (id_lat),
    .id_vec     (id_vec),
    .mem_busy   (mem_busy),
    .flush      (flush),
`ifdef HAZARD_STATS_EN
    .stats_clr  (stats_clr),
    .stall_count(stall_count),
`endif
    .issue      (issue),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .busy_vec   (busy_vec)
  );

  function automatic vec_t row(input logic r, v, input logic [3:0] s2, input logic a2,
                               input logic [3:0] s3, input logic a3, input logic [3:0] d,
                               input logic w, input logic [2:0] l, input logic vc, m, f,
                               input logic ei, es, eb, input logic [15:0] ebz);
    vec_t x;
    x.rst = r; x.valid = v; x.rs2 = s2; x.u2 = a2; x.rs3 = s3; x.u3 = a3;
    x.rd = d; x.wr = w; x.lat = l; x.vec = vc; x.mb = m; x.fl = f;
    x.e_iss = ei; x.e_stl = es; x.e_bub = eb; x.e_busy = ebz;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_valid = v.valid; id_rs2 = v.rs2; id_rs2_use = v.u2;
    id_rs3 = v.rs3; id_rs3_use = v.u3; id_rd = v.rd; id_wr = v.wr;
    id_lat = v.lat; id_vec = v.vec; mem_busy = v.mb; flush = v.fl;
    sb_q.push_back(v);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_valid = 1'b0; id_rs2 = '0; id_rs2_use = 1'b0; id_rs3 = '0;
    id_rs3_use = 1'b0; id_rd = '0; id_wr = 1'b0; id_lat = '0; id_vec = 1'b0;
    mem_busy = 1'b0; flush = 1'b0;
  endtask

  // Hard stop if anything above wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   stalls;
    idle_inputs();
    stats_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // rst valid rs2 u2 rs3 u3 rd wr lat vec mb fl | issue stall bubble busy_vec
    tbl.push_back(row(1,1, 0,0, 0,0,  5,1,3, 0,0,0, 0,0,0, 16'h0000)); // reset gates outputs
    tbl.push_back(row(1,1, 0,0, 0,0,  5,1,3, 0,0,0, 0,0,0, 16'h0000));
    tbl.push_back(row(0,1, 5,1, 0,0,  6,1,0, 0,0,0, 1,0,0, 16'h0000)); // no load during reset
    tbl.push_back(row(0,1, 0,0, 0,0,  5,1,1, 0,0,0, 1,0,0, 16'h0000)); // load-use producer
    tbl.push_back(row(0,1, 5,1, 0,0,  6,1,0, 0,0,0, 0,1,1, 16'h0020));
    tbl.push_back(row(0,1, 5,1, 0,0,  6,1,0, 0,0,0, 1,0,0, 16'h0000));
    tbl.push_back(row(0,1, 0,0, 0,0,  3,1,4, 1,0,0, 1,0,0, 16'h0000)); // vector chain
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(0,1, 0,0, 0,0, 7,1,2, 1,0,0, 0,1,1, 16'h0008));
    tbl.push_back(row(0,1, 0,0, 0,0,  7,1,2, 1,0,0, 1,0,0, 16'h0000));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0080));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0080));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0000));
    tbl.push_back(row(0,1, 0,0, 0,0,  0,1,3, 0,0,0, 1,0,0, 16'h0000)); // r0 write untracked
    tbl.push_back(row(0,1, 0,1, 0,1,  0,1,3, 0,0,0, 1,0,0, 16'h0000)); // r0 reads never stall
    tbl.push_back(row(0,1, 0,0, 0,0,  9,1,3, 0,0,0, 1,0,0, 16'h0000)); // WAW on r9
    for (int k = 0; k < 3; k++)
      tbl.push_back(row(0,1, 0,0, 0,0, 9,1,1, 0,0,0, 0,1,1, 16'h0200));
    tbl.push_back(row(0,1, 0,0, 0,0,  9,1,1, 0,0,0, 1,0,0, 16'h0000));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0200));
    tbl.push_back(row(0,1, 0,0, 0,0,  4,1,2, 0,0,0, 1,0,0, 16'h0000)); // mem_busy freeze
    for (int k = 0; k < 3; k++)
      tbl.push_back(row(0,1, 4,1, 0,0, 8,1,0, 0,1,0, 0,1,0, 16'h0010));
    tbl.push_back(row(0,1, 4,1, 0,0,  8,1,0, 0,0,0, 0,1,1, 16'h0010));
    tbl.push_back(row(0,1, 4,1, 0,0,  8,1,0, 0,0,0, 0,1,1, 16'h0010));
    tbl.push_back(row(0,1, 4,1, 0,0,  8,1,0, 0,0,0, 1,0,0, 16'h0000));
    tbl.push_back(row(0,1, 0,0, 0,0, 10,1,0, 0,1,0, 0,1,0, 16'h0000)); // mem_busy alone
    tbl.push_back(row(0,1, 0,0, 0,0, 11,1,3, 0,0,0, 1,0,0, 16'h0000)); // flush
    tbl.push_back(row(0,1,11,1, 0,0, 12,1,2, 0,0,1, 0,0,0, 16'h0800));
    tbl.push_back(row(0,1, 0,0, 0,0, 13,1,3, 0,0,1, 0,0,0, 16'h0800));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0800));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0000)); // flushed writes absent
    tbl.push_back(row(0,1, 0,0, 0,0, 14,1,7, 1,0,0, 1,0,0, 16'h0000)); // reset mid-flight
    tbl.push_back(row(1,1,14,1, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h4000));
    tbl.push_back(row(0,1, 0,0,14,1, 15,1,0, 1,0,0, 1,0,0, 16'h0000));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0000));
    tbl.push_back(row(0,1, 0,0, 0,0,  2,1,2, 0,0,0, 1,0,0, 16'h0000)); // unused sources, wr=0
    tbl.push_back(row(0,1, 2,0, 2,0,  2,0,0, 0,0,0, 1,0,0, 16'h0004));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0004));
    tbl.push_back(row(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,0,0, 16'h0000));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk($sformatf("r%0d scoreboard empty", i), 16'd0, 16'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("r%0d issue", i), 16'(issue), 16'(e.e_iss));
        chk($sformatf("r%0d stall_if", i), 16'(stall_if), 16'(e.e_stl));
        chk($sformatf("r%0d stall_id", i), 16'(stall_id), 16'(e.e_stl));
        chk($sformatf("r%0d bubble_ex", i), 16'(bubble_ex), 16'(e.e_bub));
        chk($sformatf("r%0d busy_vec", i), busy_vec, e.e_busy);
      end
      @(posedge clk); #1;
    end

    // Latency sweep: a dependent presented right after a lat=N producer
    // stalls exactly N cycles.
    for (int n = 1; n <= 7; n++) begin
      idle_inputs();
      id_valid = 1'b1; id_rd = 4'd6; id_wr = 1'b1; id_lat = 3'(n);
      @(negedge clk);
      chk($sformatf("lat%0d producer issue", n), 16'(issue), 16'd1);
      @(posedge clk); #1;
      idle_inputs();
      id_valid = 1'b1; id_rs2 = 4'd6; id_rs2_use = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (!issue && stalls < 20) begin
        stalls++;
        @(negedge clk);
      end
      chk($sformatf("lat%0d stall cycles", n), 16'(stalls), 16'(n));
      @(posedge clk); #1;
    end
    idle_inputs();

`ifdef HAZARD_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    id_valid = 1'b1; id_rd = 4'd1; id_wr = 1'b1; id_lat = 3'd3;
    @(posedge clk); #1;
    idle_inputs();
    id_valid = 1'b1; id_rs2 = 4'd1; id_rs2_use = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stats dependent issue", 16'(issue), 16'd1);
    chk("stats count after 3 bubbles", stall_count, 16'd3);
    @(posedge clk); #1;
    idle_inputs();
    id_valid = 1'b1; id_rd = 4'd1; id_wr = 1'b1; id_lat = 3'd2;
    @(posedge clk); #1;
    idle_inputs();
    id_valid = 1'b1; id_rs2 = 4'd1; id_rs2_use = 1'b1; stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats clear beats bubble", stall_count, 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stats count after clear", stall_count, 16'd1);
    @(posedge clk); #1;
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the vector ASIP: keeps a per-register scoreboard of in-flight long-latency results (loads, vector ops) and stalls the IF/ID stages, inserting an EX bubble, whenever a decoded instruction reads or rewrites a register whose value the forwarding network cannot yet supply. It also serialises access to the single non-pipelined vector unit. It sits beside the forwarding mux logic in the EX stage. Single-cycle ALU results are left entirely to forwarding.

## Interface
Parameters:
- NREG, 16, number of architectural registers (register 0 is hardwired zero)
- RW, 4, register-id width
- LAT_W, 3, latency counter width (max latency 7)

Ports:
- clk  in  1  clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decoded instruction present in ID
- id_rs2, id_rs3  in  RW  source register ids
- id_rs2_use, id_rs3_use  in  1  source actually read
- id_rd  in  RW  destination id
- id_wr  in  1  instruction writes id_rd
- id_lat  in  LAT_W  cycles until result is forwardable (0 = plain ALU)
- id_vec  in  1  instruction uses the vector unit
- mem_busy  in  1  memory stage frozen; whole pipeline holds
- flush  in  1  branch flush of the ID instruction
- issue  out  1  ID instruction advances to EX this cycle
- stall_if, stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX register
- busy_vec  out  NREG  scoreboard busy bits (bit i = register i pending)

## Operation
- Per-register counter cnt[i] (LAT_W bits); busy[i] = (cnt[i] != 0); cnt[0] always 0.
- Vector-unit counter vcnt (LAT_W bits); vector unit busy while vcnt != 0.
- hazard = (id_rs2_use & id_rs2!=0 & busy[id_rs2]) | (id_rs3_use & id_rs3!=0 & busy[id_rs3]) | (id_wr & id_rd!=0 & busy[id_rd]) (WAW) | (id_vec & vcnt!=0).
- issue = id_valid & ~flush & ~hazard & ~mem_busy.
- stall_if = stall_id = id_valid & ~flush & (hazard | mem_busy).
- bubble_ex = id_valid & ~flush & hazard & ~mem_busy. A mem_busy freeze holds ID/EX instead of bubbling it.
- On issue with id_wr & id_rd!=0 & id_lat!=0: cnt[id_rd] <= id_lat. On issue with id_vec: vcnt <= id_lat.
- Every cycle with ~mem_busy, every nonzero cnt[i] and vcnt decrements by 1. With mem_busy, all counters hold.
- A load and a decrement never hit the same register in the same cycle, because WAW blocks issue while busy. A load overrides a decrement regardless.
- flush suppresses issue and any scoreboard load. Already-issued entries keep counting.
- Writes to register 0 are never tracked. Reads of register 0 never stall.

## Timing
- Reset: all cnt and vcnt = 0. Outputs issue=0, stall_if=0, stall_id=0, bubble_ex=0, busy_vec=0.
- Hazard outputs are combinational from current scoreboard state and ID inputs. Scoreboard updates on the clk edge.
- A producer with lat=N issued in cycle t makes its dependent issuable in cycle t+N+1 at earliest. With no mem_busy, a dependent presented at t+1 is stalled N cycles.
- lat=1 (load-use) costs exactly one bubble.
- Each mem_busy cycle extends every outstanding latency by one cycle.
- rst mid-operation clears all pending entries on the next edge. No partial state survives.

## Configuration
- HAZARD_STATS_EN defined: adds output stall_count (16 bits) and input stats_clr.
  - stall_count increments every cycle bubble_ex=1 and saturates at 0xFFFF.
  - stats_clr or rst zeroes it; if both stats_clr and an increment occur in the same cycle, the clear wins.
- Not defined: neither port nor the counter exists. Stall/issue behaviour is identical.

## Structure
- Package hazard_pkg: NREG, RW, LAT_W constants, typedef regid_t (logic [RW-1:0]), typedef lat_t (logic [LAT_W-1:0]).
- Sub-module sb_entry: one down-counter with load, decrement-enable and busy output. Instantiate it NREG-1 times for registers 1..NREG-1 and once for the vector unit.
- Top holds the hazard compare logic and the optional stats counter.

## Test plan
- Reset: assert rst 2 cycles with id_valid=1 → busy_vec=0, issue=0, no stall; after release, an independent instruction issues at once.
- Load-use: issue rd=5 lat=1, next cycle rs2=5 used → exactly one cycle of stall_id=1/bubble_ex=1, then issue=1.
- Vector chain: issue vec op rd=3 lat=4; next instruction is a vec op with rd=7 and no dependence → stalls 4 cycles on vcnt, then issues; busy_vec[3] cleared by then.
- Register 0 / WAW: a lat=3 write to r0 leaves busy_vec unchanged; a lat=3 write to r9 followed by another write to r9 → second write stalls 3 cycles.
- mem_busy: lat=2 to r4, then hold mem_busy 3 cycles → cnt[4] frozen, stall_if=1, bubble_ex=0; the dependent issues 2 cycles after mem_busy drops.
- Flush/stats: flush during a hazard → issue=0, stall=0, no scoreboard load. With HAZARD_STATS_EN, 3 bubbles → stall_count=3; stats_clr → 0.
